vdp_cpu_port: RTL and testbench

- CPU-side end of the VRAM/VDP interface: decodes the two-port TMS9918-style I/O protocol (data port, control port) from Z80 bus strobes.
- Drives VRAM port A (address, write, read, write data) and the read-ahead latch.
- Holds VDP registers R0–R7 and supplies mode, name_table_addr, font_addr and video_on to the video generator.
- Owns the frame-interrupt flag and the CPU n_int output.

---
 rtl/vdp_pkg.sv | 31 +++
 rtl/vdp_regs.sv | 49 ++++
 rtl/vdp_cpu_port.sv | 145 ++++++++++++++
 tb/tb_vdp_cpu_port.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vdp_pkg.sv
// Shared constants for the VDP CPU port: register indices, display mode
// encodings, port select encodings and the prefetch FSM state type.
package vdp_pkg;

    localparam logic [2:0] R0 = 3'd0;
    localparam logic [2:0] R1 = 3'd1;
    localparam logic [2:0] R2 = 3'd2;
    localparam logic [2:0] R3 = 3'd3;
    localparam logic [2:0] R4 = 3'd4;
    localparam logic [2:0] R5 = 3'd5;
    localparam logic [2:0] R6 = 3'd6;
    localparam logic [2:0] R7 = 3'd7;

    localparam logic [1:0] MODE_TEXT = 2'd0;  // M1
    localparam logic [1:0] MODE_G1   = 2'd1;  // graphics I
    localparam logic [1:0] MODE_G2   = 2'd2;  // graphics II (M3)
    localparam logic [1:0] MODE_MC   = 2'd3;  // multicolour (M2)

    localparam logic PORT_DATA = 1'b0;  // 0x98
    localparam logic PORT_CTRL = 1'b1;  // 0x99

    localparam int NT_SHIFT_DEF = 10;
    localparam int PG_SHIFT_DEF = 11;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_RD_ISSUE   = 2'd1,
        ST_RD_CAPTURE = 2'd2
    } vdp_state_t;

endpackage

// File: rtl/vdp_regs.sv
// VDP register file R0-R7 with the derived video-generator controls.
// Outputs are combinational from the registers, so they follow a write
// on the cycle after it.
module vdp_regs
    import vdp_pkg::*;
#(
    parameter int ADDR_W   = 14,
    parameter int NT_SHIFT = NT_SHIFT_DEF,
    parameter int PG_SHIFT = PG_SHIFT_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [2:0]        idx,
    input  logic [7:0]        wdata,
    output logic [1:0]        mode,
    output logic [ADDR_W-1:0] name_table_addr,
    output logic [ADDR_W-1:0] font_addr,
    output logic              video_on,
    output logic [7:0]        text_color,
    output logic              int_en
);

    logic [7:0] regs [0:7];

    // Register file write, cleared by reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 8; i++) regs[i] <= '0;
        end else if (we) begin
            regs[idx] <= wdata;
        end
    end

    // Mode decode: M1 has priority over M3, which has priority over M2.
    always_comb begin
        mode = MODE_G1;
        if (regs[R1][4])      mode = MODE_TEXT;
        else if (regs[R0][1]) mode = MODE_G2;
        else if (regs[R1][3]) mode = MODE_MC;
    end

    assign name_table_addr = ADDR_W'(regs[R2][3:0]) << NT_SHIFT;
    assign font_addr       = ADDR_W'(regs[R4][2:0]) << PG_SHIFT;
    assign video_on        = regs[R1][6];
    assign int_en          = regs[R1][5];
    assign text_color      = regs[R7];

endmodule

// File: rtl/vdp_cpu_port.sv
// CPU side of the VDP: decodes data/control port strobes, drives VRAM
// port A, keeps the read-ahead latch and owns the frame interrupt flag.
//
// Handshake: wr_stb/rd_stb are single-cycle strobes accepted only in IDLE;
// any strobe seen while busy is dropped. vram_wr is a same-cycle pulse,
// vram_rd a one-cycle pulse whose data is captured on the following cycle.
module vdp_cpu_port
    import vdp_pkg::*;
#(
    parameter int ADDR_W   = 14,
    parameter int NT_SHIFT = NT_SHIFT_DEF,
    parameter int PG_SHIFT = PG_SHIFT_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              port_sel,
    input  logic              wr_stb,
    input  logic              rd_stb,
    input  logic [7:0]        cpu_din,
    output logic [7:0]        cpu_dout,
    output logic [ADDR_W-1:0] vram_addr,
    output logic [7:0]        vram_din,
    input  logic [7:0]        vram_dout,
    output logic              vram_wr,
    output logic              vram_rd,
    input  logic              vblank,
    output logic [1:0]        mode,
    output logic [ADDR_W-1:0] name_table_addr,
    output logic [ADDR_W-1:0] font_addr,
    output logic              video_on,
    output logic [7:0]        text_color,
    output logic              n_int,
    output logic              busy
);

    vdp_state_t  state;
    logic [7:0]  latch;
    logic [7:0]  read_ahead;
    logic        flag;
    logic        f_flag;
    logic        vblank_q;
    logic        int_en;
    logic        idle;
    logic        reg_we;
    logic        status_rd;
    logic        vblank_rise;

    assign idle        = (state == ST_IDLE);
    // Write wins over read when both strobes are present.
    assign reg_we      = idle && wr_stb && (port_sel == PORT_CTRL) && flag && cpu_din[7];
    assign status_rd   = idle && !wr_stb && rd_stb && (port_sel == PORT_CTRL);
    assign vblank_rise = vblank && !vblank_q;
    assign vram_wr     = idle && wr_stb && (port_sel == PORT_DATA);
    assign vram_din    = cpu_din;

    vdp_regs #(
        .ADDR_W   (ADDR_W),
        .NT_SHIFT (NT_SHIFT),
        .PG_SHIFT (PG_SHIFT)
    ) u_regs (
        .clk             (clk),
        .reset           (reset),
        .we              (reg_we),
        .idx             (cpu_din[2:0]),
        .wdata           (latch),
        .mode            (mode),
        .name_table_addr (name_table_addr),
        .font_addr       (font_addr),
        .video_on        (video_on),
        .text_color      (text_color),
        .int_en          (int_en)
    );

    // Port decode, prefetch FSM and interrupt flag with registered outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= ST_IDLE;
            latch      <= '0;
            read_ahead <= '0;
            flag       <= 1'b0;
            f_flag     <= 1'b0;
            vblank_q   <= 1'b0;
            vram_addr  <= '0;
            vram_rd    <= 1'b0;
            cpu_dout   <= '0;
            n_int      <= 1'b1;
            busy       <= 1'b0;
        end else begin
            vblank_q <= vblank;
            n_int    <= !(f_flag && int_en);
            vram_rd  <= 1'b0;
            busy     <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (wr_stb) begin
                        if (port_sel == PORT_CTRL) begin
                            if (!flag) begin
                                latch <= cpu_din;
                                flag  <= 1'b1;
                            end else begin
                                flag <= 1'b0;
                                if (!cpu_din[7]) begin
                                    vram_addr <= ADDR_W'({cpu_din[5:0], latch});
                                    if (!cpu_din[6]) begin
                                        state   <= ST_RD_ISSUE;
                                        vram_rd <= 1'b1;
                                        busy    <= 1'b1;
                                    end
                                end
                            end
                        end else begin
                            read_ahead <= cpu_din;
                            vram_addr  <= vram_addr + ADDR_W'(1);
                            flag       <= 1'b0;
                        end
                    end else if (rd_stb) begin
                        flag <= 1'b0;
                        if (port_sel == PORT_CTRL) begin
                            cpu_dout <= {f_flag, 7'b0};
                        end else begin
                            cpu_dout <= read_ahead;
                            state    <= ST_RD_ISSUE;
                            vram_rd  <= 1'b1;
                            busy     <= 1'b1;
                        end
                    end
                end
                ST_RD_ISSUE: begin
                    state <= ST_RD_CAPTURE;
                    busy  <= 1'b1;
                end
                ST_RD_CAPTURE: begin
                    read_ahead <= vram_dout;
                    vram_addr  <= vram_addr + ADDR_W'(1);
                    state      <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
            // A new frame edge beats a simultaneous status-read clear.
            if (vblank_rise)    f_flag <= 1'b1;
            else if (status_rd) f_flag <= 1'b0;
        end
    end

endmodule

// File: tb/tb_vdp_cpu_port.sv
// Directed bench for vdp_cpu_port with a small VRAM model and a
// scoreboard of expected VRAM writes and CPU read data.
module tb_vdp_cpu_port;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        port_sel = 1'b0;
    logic        wr_stb = 1'b0;
    logic        rd_stb = 1'b0;
    logic [7:0]  cpu_din = 8'h00;
    logic [7:0]  cpu_dout;
    logic [13:0] vram_addr;
    logic [7:0]  vram_din;
    logic [7:0]  vram_dout;
    logic        vram_wr;
    logic        vram_rd;
    logic        vblank = 1'b0;
    logic [1:0]  mode;
    logic [13:0] name_table_addr;
    logic [13:0] font_addr;
    logic        video_on;
    logic [7:0]  text_color;
    logic        n_int;
    logic        busy;

    int checks = 0;
    int errors = 0;

    logic [21:0] exp_wr_q[$];   // {addr, data}
    logic [7:0]  exp_q[$];      // CPU read data
    logic [7:0]  mem [0:16383];
    logic        rd_taken = 1'b0;

    vdp_cpu_port dut (
        .clk             (clk),
        .reset           (reset),
        .port_sel        (port_sel),
        .wr_stb          (wr_stb),
        .rd_stb          (rd_stb),
        .cpu_din         (cpu_din),
        .cpu_dout        (cpu_dout),
        .vram_addr       (vram_addr),
        .vram_din        (vram_din),
        .vram_dout       (vram_dout),
        .vram_wr         (vram_wr),
        .vram_rd         (vram_rd),
        .vblank          (vblank),
        .mode            (mode),
        .name_table_addr (name_table_addr),
        .font_addr       (font_addr),
        .video_on        (video_on),
        .text_color      (text_color),
        .n_int           (n_int),
        .busy            (busy)
    );

    // clock / reset
    always #5 clk = ~clk;

    // VRAM model: synchronous write, registered read
    always @(posedge clk) begin
        if (vram_wr) mem[vram_addr] <= vram_din;
        if (vram_rd) vram_dout <= mem[vram_addr];
    end

    always @(posedge clk) rd_taken <= rd_stb;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // monitor: compares every VRAM write and every CPU read result
    always @(negedge clk) begin
        if (reset && vram_wr) begin
            checks++;
            if (exp_wr_q.size() == 0) begin
                errors++;
                $display("FAIL vram_wr_unexpected: got addr 0x%0h data 0x%0h expected no write",
                         vram_addr, vram_din);
            end else begin
                logic [21:0] e;
                e = exp_wr_q.pop_front();
                if ({vram_addr, vram_din} !== e) begin
                    errors++;
                    $display("FAIL vram_wr: got addr 0x%0h data 0x%0h expected addr 0x%0h data 0x%0h",
                             vram_addr, vram_din, e[21:8], e[7:0]);
                end
            end
        end
        if (reset && rd_taken) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL cpu_dout_unexpected: got 0x%0h expected no read", cpu_dout);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (cpu_dout !== e) begin
                    errors++;
                    $display("FAIL cpu_dout: got 0x%0h expected 0x%0h", cpu_dout, e);
                end
            end
        end
    end

    // driver: one strobe, then gap idle cycles
    task automatic strobe(input logic wr, input logic rd, input logic port,
                          input logic [7:0] d, input logic vb, input int gap);
        wr_stb   = wr;
        rd_stb   = rd;
        port_sel = port;
        cpu_din  = d;
        vblank   = vb;
        @(posedge clk); #1;
        wr_stb = 1'b0;
        rd_stb = 1'b0;
        vblank = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
    endtask

    task automatic ctrl_wr(input logic [7:0] d);
        strobe(1'b1, 1'b0, 1'b1, d, 1'b0, 3);
    endtask

    task automatic data_wr(input logic [13:0] a, input logic [7:0] d);
        exp_wr_q.push_back({a, d});
        strobe(1'b1, 1'b0, 1'b0, d, 1'b0, 3);
    endtask

    task automatic data_rd(input logic [7:0] e);
        exp_q.push_back(e);
        strobe(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 3);
    endtask

    task automatic status_rd(input logic [7:0] e, input logic vb);
        exp_q.push_back(e);
        strobe(1'b0, 1'b1, 1'b1, 8'h00, vb, 3);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    initial begin
        for (int i = 0; i < 16384; i++) mem[i] = 8'h00;
        mem[14'h1234] = 8'hAB;
        mem[14'h1235] = 8'hCD;

        reset = 1'b0;
        wait_cycles(3);
        check("rst_mode", 16'(mode), 16'd1);
        check("rst_video_on", 16'(video_on), 16'd0);
        check("rst_nt", 16'(name_table_addr), 16'h0);
        check("rst_font", 16'(font_addr), 16'h0);
        check("rst_text", 16'(text_color), 16'h0);
        check("rst_addr", 16'(vram_addr), 16'h0);
        check("rst_vram_rd", 16'(vram_rd), 16'd0);
        check("rst_vram_wr", 16'(vram_wr), 16'd0);
        check("rst_dout", 16'(cpu_dout), 16'h0);
        check("rst_n_int", 16'(n_int), 16'd1);
        check("rst_busy", 16'(busy), 16'd0);
        reset = 1'b1;
        wait_cycles(1);

        // register writes
        ctrl_wr(8'hF0); ctrl_wr(8'h87);
        check("text_color", 16'(text_color), 16'h00F0);
        ctrl_wr(8'h70); ctrl_wr(8'h81);
        check("video_on", 16'(video_on), 16'd1);
        check("mode_text", 16'(mode), 16'd0);
        check("n_int_no_f", 16'(n_int), 16'd1);
        ctrl_wr(8'h05); ctrl_wr(8'h82);
        check("name_table", 16'(name_table_addr), 16'h1400);
        ctrl_wr(8'h07); ctrl_wr(8'h84);
        check("font_addr", 16'(font_addr), 16'h3800);
        ctrl_wr(8'h00); ctrl_wr(8'h81);
        check("mode_g1", 16'(mode), 16'd1);
        ctrl_wr(8'h02); ctrl_wr(8'h80);
        check("mode_g2", 16'(mode), 16'd2);
        ctrl_wr(8'h08); ctrl_wr(8'h81);
        check("mode_g2_over_mc", 16'(mode), 16'd2);
        ctrl_wr(8'h00); ctrl_wr(8'h80);
        check("mode_mc", 16'(mode), 16'd3);

        // write setup, two data writes
        ctrl_wr(8'h00); ctrl_wr(8'h40);
        data_wr(14'h0000, 8'h11);
        data_wr(14'h0001, 8'h22);
        check("wr_addr_end", 16'(vram_addr), 16'h0002);

        // read setup with prefetch, two data reads
        ctrl_wr(8'h34); ctrl_wr(8'h12);
        check("prefetch_addr", 16'(vram_addr), 16'h1235);
        data_rd(8'hAB);
        check("rd_addr_1", 16'(vram_addr), 16'h1236);
        data_rd(8'hCD);
        check("rd_addr_2", 16'(vram_addr), 16'h1237);

        // address wrap on data write
        ctrl_wr(8'hFF); ctrl_wr(8'h7F);
        check("wrap_setup", 16'(vram_addr), 16'h3FFF);
        data_wr(14'h3FFF, 8'h5A);
        check("wrap_addr", 16'(vram_addr), 16'h0000);

        // interrupt flag
        ctrl_wr(8'h20); ctrl_wr(8'h81);
        vblank = 1'b1; wait_cycles(1); vblank = 1'b0;
        wait_cycles(2);
        check("n_int_set", 16'(n_int), 16'd0);
        status_rd(8'h80, 1'b0);
        check("n_int_clr", 16'(n_int), 16'd1);
        status_rd(8'h00, 1'b0);
        // frame edge coincides with status read: old F returned, F stays set
        status_rd(8'h00, 1'b1);
        check("n_int_coincide", 16'(n_int), 16'd0);
        status_rd(8'h80, 1'b0);
        check("n_int_clr2", 16'(n_int), 16'd1);

        // data read clears the second-byte flag
        ctrl_wr(8'h55);
        data_rd(8'h5A);
        ctrl_wr(8'h00); ctrl_wr(8'h40);
        check("flag_reset_addr", 16'(vram_addr), 16'h0000);

        // write strobe during prefetch is dropped
        ctrl_wr(8'h00);
        strobe(1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 0);
        strobe(1'b1, 1'b0, 1'b0, 8'h99, 1'b0, 3);
        check("busy_drop_addr", 16'(vram_addr), 16'h0001);
        data_rd(8'h11);

        // reset in the middle of a prefetch
        ctrl_wr(8'h34);
        strobe(1'b1, 1'b0, 1'b1, 8'h12, 1'b0, 0);
        reset = 1'b0;
        wait_cycles(2);
        reset = 1'b1;
        wait_cycles(2);
        check("abort_busy", 16'(busy), 16'd0);
        check("abort_addr", 16'(vram_addr), 16'h0000);
        data_rd(8'h00);

        wait_cycles(3);
        check("wr_queue_empty", 16'(exp_wr_q.size()), 16'd0);
        check("rd_queue_empty", 16'(exp_q.size()), 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
